// File: rtl/fast_field_encoder_pkg.sv
// Shared FAST constants, types and the stop-bit length helper used by the
// encoder (and the matching decoder path).
package fast_field_encoder_pkg;

    localparam logic [7:0] FAST_STOP_BIT       = 8'h80;
    localparam int         FAST_GROUP_BITS     = 7;
    localparam int         FAST_LEN_VALUE_BITS = 128;
    localparam int         FAST_LEN_MAX_GROUPS = (FAST_LEN_VALUE_BITS + FAST_GROUP_BITS - 1) / FAST_GROUP_BITS;

    typedef logic [7:0] fast_byte_t;

    typedef struct packed {
        logic [63:0] value;
        logic        is_signed;
        logic        last;
    } fast_field_t;

    typedef struct packed {
        logic [63:0] data;
        logic [3:0]  nbytes;
        logic        last;
    } fast_beat_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FILL  = 2'd1,
        ST_DRAIN = 2'd2
    } enc_state_t;

    // Caller zero- or sign-extends the value to FAST_LEN_VALUE_BITS. "Fits in k
    // groups" is monotonic in k, so every k that does not fit pushes n to k+1.
    function automatic int fast_enc_len(input logic [FAST_LEN_VALUE_BITS-1:0] value,
                                        input logic is_signed);
        int n;
        logic [FAST_LEN_VALUE_BITS-1:0] rest;
        n = 1;
        for (int k = 1; k < FAST_LEN_MAX_GROUPS; k++) begin
            if (is_signed) begin
                rest = FAST_LEN_VALUE_BITS'($signed(value) >>> (FAST_GROUP_BITS * k - 1));
                if (rest != '0 && rest != '1) n = k + 1;
            end else begin
                rest = value >> (FAST_GROUP_BITS * k);
                if (rest != '0) n = k + 1;
            end
        end
        return n;
    endfunction

endpackage

// File: rtl/fast_field_encoder_if.sv
// Field-in / beat-out handshake bundle of the FAST field encoder.
interface fast_field_encoder_if #(
    parameter int beat_width      = 64,
    parameter int max_value_width = 64
) ();
    localparam int beat_bytes = beat_width / 8;
    localparam int lane_w     = $clog2(beat_bytes) + 1;

    logic [max_value_width-1:0] din_value;
    logic                       din_signed;
    logic                       din_last;
    logic                       din_valid;
    logic                       din_ready;
    logic [beat_width-1:0]      dout;
    logic                       dout_valid;
    logic                       dout_ready;
    logic                       dout_last;
    logic [lane_w-1:0]          dout_bytes;

    modport master (
        output din_value, din_signed, din_last, din_valid, dout_ready,
        input  din_ready, dout, dout_valid, dout_last, dout_bytes
    );

    modport slave (
        input  din_value, din_signed, din_last, din_valid, dout_ready,
        output din_ready, dout, dout_valid, dout_last, dout_bytes
    );
endinterface

// File: rtl/fast_field_encoder_stopbit_enc.sv
// Combinational FAST stop-bit encoder: one integer in, up to max_enc_bytes
// bytes out, most significant group in byte 0.
module fast_stopbit_enc
    import fast_field_encoder_pkg::*;
#(
    parameter int max_value_width = 64,
    parameter int max_enc_bytes   = (max_value_width + 6) / 7,
    parameter int len_w           = $clog2(max_enc_bytes + 1)
) (
    input  logic [max_value_width-1:0]      value,
    input  logic                            is_signed,
    output logic [max_enc_bytes-1:0][7:0]   enc_bytes,
    output logic [len_w-1:0]                enc_len
);
    logic [FAST_LEN_VALUE_BITS-1:0] wide;
    int                             enc_n;

    assign wide    = {{(FAST_LEN_VALUE_BITS - max_value_width){is_signed & value[max_value_width-1]}}, value};
    assign enc_n   = fast_enc_len(wide, is_signed);
    assign enc_len = len_w'(enc_n);

    genvar gi;
    generate
        for (gi = 0; gi < max_enc_bytes; gi++) begin : g_byte
            logic [7:0] byte_val;
            always_comb begin
                byte_val = 8'h00;
                if (gi < enc_n) begin
                    byte_val = {1'b0, wide[FAST_GROUP_BITS * (enc_n - 1 - gi) +: FAST_GROUP_BITS]};
                    if (gi == enc_n - 1) byte_val = byte_val | FAST_STOP_BIT;
                end
            end
            assign enc_bytes[gi] = byte_val;
        end
    endgenerate
endmodule

// File: rtl/fast_field_encoder.sv
// FAST field encoder: stop-bit encodes fields, packs bytes MSB-lane first into
// beats and closes each message with a byte-counted final beat.
module fast_field_encoder
    import fast_field_encoder_pkg::*;
#(
    parameter int beat_width      = 64,
    parameter int max_value_width = 64
) (
    input  logic                 clk,
    input  logic                 rstn,
    fast_field_encoder_if.slave  bus,
    output logic                 busy
);
    localparam int beat_bytes    = beat_width / 8;
    localparam int max_enc_bytes = (max_value_width + FAST_GROUP_BITS - 1) / FAST_GROUP_BITS;
    localparam int buf_bytes     = 3 * beat_bytes;
    localparam int fill_w        = $clog2(buf_bytes + 1);
    localparam int len_w         = $clog2(max_enc_bytes + 1);
    localparam int lane_w        = $clog2(beat_bytes) + 1;
    localparam int enc_idx_w     = (max_enc_bytes > 1) ? $clog2(max_enc_bytes) : 1;

    enc_state_t                     state_reg, state_next;
    logic [fill_w-1:0]              fill_reg, fill_next, wr_base;
    logic [buf_bytes-1:0][7:0]      buf_view;
    logic [max_enc_bytes-1:0][7:0]  enc_bytes;
    logic [len_w-1:0]               enc_len;
    logic [beat_width-1:0]          dout_word;
    logic                           drain, accept, pop;

    fast_stopbit_enc #(
        .max_value_width (max_value_width),
        .max_enc_bytes   (max_enc_bytes),
        .len_w           (len_w)
    ) u_enc (
        .value     (bus.din_value),
        .is_signed (bus.din_signed),
        .enc_bytes (enc_bytes),
        .enc_len   (enc_len)
    );

    // Ready depends on registered state only, so upstream sees no comb path.
    assign drain          = (state_reg == ST_DRAIN);
    assign bus.din_ready  = !drain && (fill_reg <= fill_w'(buf_bytes - max_enc_bytes));
    assign bus.dout_valid = (fill_reg >= fill_w'(beat_bytes)) || (drain && fill_reg != '0);
    assign bus.dout_bytes = (fill_reg >= fill_w'(beat_bytes)) ? lane_w'(beat_bytes) : lane_w'(fill_reg);
    assign bus.dout_last  = drain && (fill_reg <= fill_w'(beat_bytes));
    assign busy           = (fill_reg != '0) || drain;

    assign accept    = bus.din_valid && bus.din_ready;
    assign pop       = bus.dout_valid && bus.dout_ready;
    assign wr_base   = pop ? (fill_reg - fill_w'(bus.dout_bytes)) : fill_reg;
    assign fill_next = wr_base + (accept ? fill_w'(enc_len) : fill_w'(0));

    always_comb begin
        dout_word = '0;
        for (int k = 0; k < beat_bytes; k++) begin
            if (k < int'(fill_reg)) dout_word[beat_width - 1 - 8 * k -: 8] = buf_view[k];
        end
    end
    assign bus.dout = dout_word;

    // Each lane shifts down a whole beat on a pop, then may take an encoded
    // byte if it falls in the append window that starts after the shift.
    genvar gi;
    generate
        for (gi = 0; gi < buf_bytes; gi++) begin : g_lane
            logic [7:0]        byte_reg, byte_next, shifted;
            logic [fill_w-1:0] lane_off;
            logic              in_window;

            if (gi + beat_bytes < buf_bytes) begin : g_src
                assign shifted = buf_view[gi + beat_bytes];
            end else begin : g_zero
                assign shifted = 8'h00;
            end

            assign lane_off  = fill_w'(gi) - wr_base;
            assign in_window = accept && (fill_w'(gi) >= wr_base) && (lane_off < fill_w'(enc_len));

            always_comb begin
                byte_next = pop ? shifted : byte_reg;
                if (in_window) byte_next = enc_bytes[lane_off[enc_idx_w-1:0]];
            end

            always_ff @(posedge clk) begin
                if (!rstn) byte_reg <= 8'h00;
                else       byte_reg <= byte_next;
            end

            assign buf_view[gi] = byte_reg;
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_reg <= ST_IDLE;
            fill_reg  <= '0;
        end else begin
            state_reg <= state_next;
            fill_reg  <= fill_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE, ST_FILL: begin
                if (accept && bus.din_last) state_next = ST_DRAIN;
                else if (fill_next == '0)   state_next = ST_IDLE;
                else                        state_next = ST_FILL;
            end
            ST_DRAIN: begin
                if (pop && bus.dout_last) state_next = ST_IDLE;
            end
            default: state_next = ST_IDLE;
        endcase
    end
endmodule
